hp_controller: RTL and testbench

Player-HP owner for the battle screen and the initiating end of the damage-calculation handshake. Once per frame it requests a damage evaluation by raising `start`, waits for `isComplete`, and subtracts the returned `damage` from the player HP with saturation. It then enforces an invulnerability window and latches a dead state until the game issues a revive. It sits between the frame timing logic and the damage calculator, and feeds the HUD/render path.

---
 rtl/hp_controller.sv | 85 ++++++++
 tb/tb_hp_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hp_controller.sv
// hp_controller: player HP owner driving the damage-calculation handshake.
//   clk, reset         : clock, synchronous active-high reset
//   frameTick          : one-cycle request for a damage evaluation (honoured in IDLE only)
//   damage, isComplete : calculator result and its done strobe (sampled in WAIT only)
//   revive             : restores HP to MAX_HP from the dead state
//   start              : request to the calculator, high for every cycle spent waiting
//   hp                 : current HP, saturating at 0
//   isDead, isInvuln   : dead flag, invulnerability window flag
//   hitPulse           : one-cycle pulse per applied non-zero hit
//   timeoutCount       : abandoned requests, saturating at 255
module hp_controller #(
    parameter int MAX_HP         = 20,
    parameter int INVULN_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frameTick,
    input  logic [7:0] damage,
    input  logic       isComplete,
    input  logic       revive,
    output logic       start,
    output logic [7:0] hp,
    output logic       isDead,
    output logic       isInvuln,
    output logic       hitPulse,
    output logic [7:0] timeoutCount
);
    typedef enum logic [2:0] {IDLE, WAIT, APPLY, INVULN, DEAD} state_t;

    state_t      state, next;
    logic [15:0] wcnt, icnt;
    logic [7:0]  dmg, hp_sub;
    logic        wait_last, invuln_last;

    assign hp_sub      = hp > dmg ? hp - dmg : 8'd0;
    assign wait_last   = wcnt == 16'(TIMEOUT_CYCLES - 1);
    assign invuln_last = icnt == 16'(INVULN_CYCLES - 1);

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = frameTick ? WAIT : IDLE;
            // completion takes priority over the timeout on the final cycle
            WAIT:    next = isComplete ? APPLY : wait_last ? IDLE : WAIT;
            APPLY:   next = dmg == 8'd0 ? IDLE : hp_sub == 8'd0 ? DEAD : INVULN;
            INVULN:  next = invuln_last ? IDLE : INVULN;
            DEAD:    next = revive ? IDLE : DEAD;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hp           <= 8'(MAX_HP);
            start        <= 1'b0;
            isDead       <= 1'b0;
            isInvuln     <= 1'b0;
            hitPulse     <= 1'b0;
            timeoutCount <= 8'd0;
            wcnt         <= 16'd0;
            icnt         <= 16'd0;
            dmg          <= 8'd0;
        end else begin
            state    <= next;
            // start and isInvuln trail the state by one cycle so each is high
            // for exactly as many cycles as the state is held
            start    <= state == WAIT;
            isInvuln <= state == INVULN;
            isDead   <= next == DEAD;
            hitPulse <= state == APPLY && dmg != 8'd0;
            wcnt     <= state == WAIT ? wcnt + 16'd1 : 16'd0;
            icnt     <= state == INVULN ? icnt + 16'd1 : 16'd0;
            if (state == WAIT && isComplete)
                dmg <= damage;
            if (state == APPLY && dmg != 8'd0)
                hp <= hp_sub;
            if (state == DEAD && revive)
                hp <= 8'(MAX_HP);
            if (state == WAIT && !isComplete && wait_last && timeoutCount != 8'd255)
                timeoutCount <= timeoutCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_hp_controller.sv
// tb_hp_controller: randomized transaction-level check of hp_controller against an HP/timeout model.
module tb_hp_controller;
    localparam int MAXHP = 20;
    localparam int INV   = 16;
    localparam int TO    = 64;

    logic       clk = 1'b0, reset = 1'b1, frameTick = 1'b0, isComplete = 1'b0, revive = 1'b0;
    logic [7:0] damage = 8'd0;
    logic       start, isDead, isInvuln, hitPulse;
    logic [7:0] hp, timeoutCount;

    int n_vec = 0, n_err = 0;
    int m_hp = MAXHP, m_to = 0;

    hp_controller #(.MAX_HP(MAXHP), .INVULN_CYCLES(INV), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .frameTick(frameTick), .damage(damage),
        .isComplete(isComplete), .revive(revive), .start(start), .hp(hp),
        .isDead(isDead), .isInvuln(isInvuln), .hitPulse(hitPulse),
        .timeoutCount(timeoutCount)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One request issued from IDLE: either times out, or completes after d cycles with damage v.
    task automatic frame(input int d, input int v, input bit timeout);
        int cnt, starts, exp;
        frameTick = 1'b1;
        tick;
        frameTick = 1'b0;
        check("start_lag", start, 0);
        cnt = 0;
        if (timeout) begin
            for (int k = 0; k < TO + 4; k++) begin
                damage = 8'($urandom_range(0, 255));
                tick;
                if (start) cnt++;
            end
            m_to = m_to < 255 ? m_to + 1 : 255;
            check("timeout_len", cnt, TO);
            check("timeout_cnt", timeoutCount, m_to);
            check("timeout_hp", hp, m_hp);
        end else begin
            for (int k = 1; k <= d; k++) begin
                isComplete = k == d;
                damage = k == d ? 8'(v) : 8'($urandom_range(0, 255));
                tick;
                if (start) cnt++;
            end
            isComplete = 1'b0;
            damage = 8'($urandom_range(0, 255));
            tick;
            exp = m_hp > v ? m_hp - v : 0;
            check("start_len", cnt, d);
            check("start_drop", start, 0);
            check("hp", hp, exp);
            check("hit_pulse", hitPulse, v != 0);
            check("dead_flag", isDead, exp == 0);
            check("invuln_pre", isInvuln, 0);
            m_hp = exp;
            if (v != 0 && exp != 0) begin
                cnt = 0;
                starts = 0;
                for (int k = 0; k < INV + 4; k++) begin
                    frameTick = k < INV ? 1'($urandom_range(0, 1)) : 1'b0;
                    tick;
                    if (isInvuln) cnt++;
                    if (start) starts++;
                end
                frameTick = 1'b0;
                check("invuln_len", cnt, INV);
                check("invuln_nostart", starts, 0);
                check("invuln_hp", hp, m_hp);
            end else if (exp == 0) begin
                starts = 0;
                for (int k = 0; k < 5; k++) begin
                    frameTick = 1'($urandom_range(0, 1));
                    tick;
                    if (start) starts++;
                end
                check("dead_nostart", starts, 0);
                check("dead_hp", hp, 0);
                check("dead_hold", isDead, 1);
                revive = 1'b1;
                frameTick = 1'($urandom_range(0, 1));
                tick;
                revive = 1'b0;
                frameTick = 1'b0;
                m_hp = MAXHP;
                check("revive_hp", hp, MAXHP);
                check("revive_alive", isDead, 0);
                tick;
                check("revive_drop", start, 0);
            end
        end
    endtask

    initial begin
        int v;
        repeat (2) tick;
        check("rst_hp", hp, MAXHP);
        check("rst_start", start, 0);
        check("rst_dead", isDead, 0);
        check("rst_invuln", isInvuln, 0);
        check("rst_hit", hitPulse, 0);
        check("rst_to", timeoutCount, 0);
        reset = 1'b0;
        tick;

        frame(3, 5, 1'b0);
        frame(2, 0, 1'b0);
        frame(1, 0, 1'b0);
        frame(TO, 4, 1'b0);
        for (int i = 0; i < 60; i++) begin
            v = $urandom_range(0, 9) < 2 ? 0 : $urandom_range(0, 9) == 0 ? $urandom_range(0, 255) : $urandom_range(1, 8);
            frame($urandom_range(1, TO), v, $urandom_range(0, 7) == 0);
        end

        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_hp = MAXHP;
        m_to = 0;
        check("rst2_hp", hp, MAXHP);
        frame(3, 17, 1'b0);
        frame(2, 200, 1'b0);

        isComplete = 1'b1;
        damage = 8'd9;
        tick;
        isComplete = 1'b0;
        tick;
        check("idle_cmpl_start", start, 0);
        check("idle_cmpl_hp", hp, m_hp);

        for (int i = 0; i < 300; i++) frame(1, 0, 1'b1);
        check("to_sat", timeoutCount, 255);

        frameTick = 1'b1;
        tick;
        frameTick = 1'b0;
        tick;
        check("mid_start", start, 1);
        reset = 1'b1;
        isComplete = 1'b1;
        damage = 8'd5;
        tick;
        reset = 1'b0;
        isComplete = 1'b0;
        check("mid_rst_start", start, 0);
        check("mid_rst_hp", hp, MAXHP);
        check("mid_rst_to", timeoutCount, 0);
        tick;
        tick;
        check("mid_rst_hit", hitPulse, 0);
        check("mid_rst_hp2", hp, MAXHP);
        m_hp = MAXHP;
        m_to = 0;
        frame(4, 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
